// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: KSA state encoding, S-box geometry and key-size limit.
package rc4_pkg;

    localparam int          S_SIZE        = 256;
    localparam logic [7:0]  S_LAST        = 8'd255;
    localparam int          KEY_BYTES_MAX = 32;

    typedef enum logic [3:0] {
        IDLE,
        INIT_WR,
        RD_I,
        WAIT_I,
        CAP_I,
        RD_J,
        WAIT_J,
        CAP_J,
        WR_I,
        WR_J,
        NEXT,
        DONE
    } ksa_state_t;

endpackage

// File: rtl/flopr_en.sv
// Enabled register with synchronous clear; clear has priority over enable.
module flopr_en #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clr)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/ksa_key_sel.sv
// Selects key byte kidx from the packed key; byte 0 is the most-significant byte.
module ksa_key_sel #(
    parameter int KEY_LENGTH = 3,
    parameter int KIDX_W     = 5
) (
    input  logic [8*KEY_LENGTH-1:0] secret_key,
    input  logic [KIDX_W-1:0]       kidx,
    output logic [7:0]              key_byte
);

    // NOTE: the default assignment before the loop keeps this purely combinational (no latch).
    always_comb begin
        key_byte = '0;
        for (int k = 0; k < KEY_LENGTH; k++) begin
            if (kidx == KIDX_W'(k))
                key_byte = secret_key[8*(KEY_LENGTH-k)-1 -: 8];
        end
    end

endmodule

// File: rtl/ksa_shuffle.sv
// RC4 key-scheduling shuffle over a single-port S RAM with fixed read latency.
// Define KSA_INIT_EN to run the identity-fill pass before the shuffle.
module ksa_shuffle
    import rc4_pkg::*;
#(
    parameter int KEY_LENGTH  = 3,
    parameter int RAM_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [8*KEY_LENGTH-1:0] secret_key,
    input  logic [7:0]              read_data,
    output logic [7:0]              address,
    output logic [7:0]              data,
    output logic                    write_en,
    output logic                    finished
);

    localparam int         KIDX_W    = $clog2(KEY_BYTES_MAX);
    localparam logic [7:0] WAIT_LAST = 8'(RAM_LATENCY - 1);

    ksa_state_t        state, state_next;
    logic [7:0]        i, j, si, sj;
    logic [KIDX_W-1:0] kidx;
    logic [7:0]        key_byte;
    logic [7:0]        wait_cnt;
    logic              wait_done;

    logic              i_en, j_en, si_en, sj_en, kidx_en, addr_en, data_en, we_next;
    logic [7:0]        i_d, j_d, addr_d, data_d;
    logic [KIDX_W-1:0] kidx_d;

    ksa_key_sel #(.KEY_LENGTH(KEY_LENGTH), .KIDX_W(KIDX_W)) u_key_sel (
        .secret_key (secret_key),
        .kidx       (kidx),
        .key_byte   (key_byte)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Counts cycles spent in either wait state; address is held stable meanwhile.
    always_ff @(posedge clk) begin
        if (reset)
            wait_cnt <= '0;
        else if (state == WAIT_I || state == WAIT_J)
            wait_cnt <= wait_cnt + 8'd1;
        else
            wait_cnt <= '0;
    end

    assign wait_done = (wait_cnt == WAIT_LAST);

    always_comb begin
        state_next = state;
        i_en       = 1'b0;
        i_d        = i;
        j_en       = 1'b0;
        j_d        = j;
        si_en      = 1'b0;
        sj_en      = 1'b0;
        kidx_en    = 1'b0;
        kidx_d     = kidx;
        addr_en    = 1'b0;
        addr_d     = address;
        data_en    = 1'b0;
        data_d     = data;
        we_next    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    i_en    = 1'b1;
                    i_d     = '0;
                    j_en    = 1'b1;
                    j_d     = '0;
                    kidx_en = 1'b1;
                    kidx_d  = '0;
`ifdef KSA_INIT_EN
                    state_next = INIT_WR;
`else
                    state_next = RD_I;
`endif
                end
            end
`ifdef KSA_INIT_EN
            INIT_WR: begin
                addr_en = 1'b1;
                addr_d  = i;
                data_en = 1'b1;
                data_d  = i;
                we_next = 1'b1;
                i_en    = 1'b1;
                if (i == S_LAST) begin
                    i_d        = '0;
                    state_next = RD_I;
                end else begin
                    i_d = i + 8'd1;
                end
            end
`endif
            RD_I: begin
                addr_en    = 1'b1;
                addr_d     = i;
                state_next = (RAM_LATENCY == 0) ? CAP_I : WAIT_I;
            end
            WAIT_I: if (wait_done) state_next = CAP_I;
            CAP_I: begin
                si_en      = 1'b1;
                j_en       = 1'b1;
                j_d        = j + read_data + key_byte;
                state_next = RD_J;
            end
            RD_J: begin
                addr_en    = 1'b1;
                addr_d     = j;
                state_next = (RAM_LATENCY == 0) ? CAP_J : WAIT_J;
            end
            WAIT_J: if (wait_done) state_next = CAP_J;
            CAP_J: begin
                sj_en      = 1'b1;
                state_next = WR_I;
            end
            WR_I: begin
                addr_en    = 1'b1;
                addr_d     = i;
                data_en    = 1'b1;
                data_d     = sj;
                we_next    = 1'b1;
                state_next = WR_J;
            end
            WR_J: begin
                addr_en    = 1'b1;
                addr_d     = j;
                data_en    = 1'b1;
                data_d     = si;
                we_next    = 1'b1;
                state_next = NEXT;
            end
            NEXT: begin
                kidx_en = 1'b1;
                kidx_d  = (kidx == KIDX_W'(KEY_LENGTH - 1)) ? '0 : kidx + KIDX_W'(1);
                if (i == S_LAST) begin
                    state_next = DONE;
                end else begin
                    i_en       = 1'b1;
                    i_d        = i + 8'd1;
                    state_next = RD_I;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    flopr_en #(.WIDTH(8))      u_i    (.clk(clk), .clr(reset), .en(i_en),    .d(i_d),       .q(i));
    flopr_en #(.WIDTH(8))      u_j    (.clk(clk), .clr(reset), .en(j_en),    .d(j_d),       .q(j));
    flopr_en #(.WIDTH(8))      u_si   (.clk(clk), .clr(reset), .en(si_en),   .d(read_data), .q(si));
    flopr_en #(.WIDTH(8))      u_sj   (.clk(clk), .clr(reset), .en(sj_en),   .d(read_data), .q(sj));
    flopr_en #(.WIDTH(KIDX_W)) u_kidx (.clk(clk), .clr(reset), .en(kidx_en), .d(kidx_d),    .q(kidx));
    flopr_en #(.WIDTH(8))      u_addr (.clk(clk), .clr(reset), .en(addr_en), .d(addr_d),    .q(address));
    flopr_en #(.WIDTH(8))      u_data (.clk(clk), .clr(reset), .en(data_en), .d(data_d),    .q(data));

    // Registered strobe: reset clears it on the same edge, so an aborted write never lands.
    always_ff @(posedge clk) begin
        if (reset)
            write_en <= 1'b0;
        else
            write_en <= we_next;
    end

    assign finished = (state == DONE);

endmodule

// File: tb/tb_ksa_shuffle.sv
// Randomised self-checking bench for ksa_shuffle against a software RC4 KSA model
// driving a latency-accurate S RAM model.
module tb_ksa_shuffle;

    localparam int KEY_LENGTH  = 3;
    localparam int RAM_LATENCY = 2;
    localparam int KW          = 8 * KEY_LENGTH;
`ifdef KSA_INIT_EN
    localparam int INIT_CYCLES = 256;
`else
    localparam int INIT_CYCLES = 0;
`endif
    localparam int RUN_CYCLES  = 256 * (7 + 2 * RAM_LATENCY) + 2 + INIT_CYCLES;
    localparam int RUN_WRITES  = 512 + INIT_CYCLES;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [KW-1:0] secret_key = '0;
    logic [7:0]    read_data, address, data;
    logic          write_en, finished;

    ksa_shuffle #(.KEY_LENGTH(KEY_LENGTH), .RAM_LATENCY(RAM_LATENCY)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .secret_key (secret_key),
        .read_data  (read_data),
        .address    (address),
        .data       (data),
        .write_en   (write_en),
        .finished   (finished)
    );

    always #5 clk = ~clk;

    // S RAM: synchronous write, read data valid RAM_LATENCY edges after the address.
    logic [7:0] mem [256];
    logic [7:0] rd_pipe [RAM_LATENCY];
    logic       preload = 1'b0;

    always @(posedge clk) begin
        if (preload)
            for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
        else if (write_en)
            mem[address] <= data;
        rd_pipe[0] <= mem[address];
        for (int k = 1; k < RAM_LATENCY; k++) rd_pipe[k] <= rd_pipe[k-1];
    end

    assign read_data = rd_pipe[RAM_LATENCY-1];

    logic [7:0] wr_addr [$];
    logic [7:0] wr_data [$];

    always @(negedge clk) begin
        if (write_en) begin
            wr_addr.push_back(address);
            wr_data.push_back(data);
        end
    end

    int n_vec = 0;
    int n_err = 0;
    int exp_s [256];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic preload_identity();
        @(negedge clk);
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
    endtask

    // Reference KSA on an integer array, starting from identity or the current RAM.
    task automatic prep_model(input logic [KW-1:0] key);
        int jj, kb, t;
        for (int k = 0; k < 256; k++) exp_s[k] = (INIT_CYCLES != 0) ? k : int'(mem[k]);
        jj = 0;
        for (int ii = 0; ii < 256; ii++) begin
            kb = int'((key >> (8 * (KEY_LENGTH - 1 - (ii % KEY_LENGTH)))) & 8'hFF);
            jj = (jj + exp_s[ii] + kb) % 256;
            t = exp_s[ii]; exp_s[ii] = exp_s[jj]; exp_s[jj] = t;
        end
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic launch(input logic [KW-1:0] key);
        @(negedge clk);
        secret_key = key;
        prep_model(key);
        start = 1'b1;
    endtask

    // n counts negedges; the negedge in cycle c (cycle 1 = the IDLE cycle sampling start) has n = c-1.
    task automatic await_finish(input int n0, input bit hold, input bit pulse_mid, input string name);
        int n;
        bit seen;
        n = n0;
        seen = 1'b0;
        while (!seen && n < RUN_CYCLES + 100) begin
            @(negedge clk);
            n++;
            if (pulse_mid && n >= 500 && n < 503) start = 1'b1;
            else if (!hold && n >= 1)             start = 1'b0;
            if (finished) seen = 1'b1;
        end
        check({name, " finished seen"}, 32'(seen), 32'd1);
        check({name, " latency"}, 32'(n + 1), 32'(RUN_CYCLES));
        check({name, " write count"}, 32'(wr_addr.size()), 32'(RUN_WRITES));
        for (int k = 0; k < 256; k++) check({name, " sbox"}, 32'(mem[k]), 32'(exp_s[k]));
    endtask

    function automatic logic [7:0] first_keystream();
        logic [7:0] s [256];
        logic [7:0] a, b, jj;
        for (int k = 0; k < 256; k++) s[k] = mem[k];
        a = s[1];
        jj = a;
        b = s[jj];
        s[1] = b;
        s[jj] = a;
        return s[8'(a + b)];
    endfunction

    initial begin
        int base, errs, sz;
        logic [KW-1:0] key;

        // Reset for three cycles, RAM preloaded meanwhile.
        preload = 1'b1;
        repeat (3) @(negedge clk);
        preload = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("reset address", 32'(address), 32'd0);
        check("reset data", 32'(data), 32'd0);
        check("reset write_en", 32'(write_en), 32'd0);
        check("reset finished", 32'(finished), 32'd0);
        repeat (5) @(negedge clk);
        check("idle no writes", 32'(wr_addr.size()), 32'd0);

        // All-zero key: first iteration has i == j == 0, second lands on j == 1.
        launch('0);
        await_finish(0, 1'b0, 1'b0, "zero key");
        base = INIT_CYCLES;
        if (wr_addr.size() >= base + 4) begin
            check("zero key wr0 addr", 32'(wr_addr[base]),   32'd0);
            check("zero key wr0 data", 32'(wr_data[base]),   32'd0);
            check("zero key wr1 addr", 32'(wr_addr[base+1]), 32'd0);
            check("zero key wr1 data", 32'(wr_data[base+1]), 32'd0);
            check("zero key wr2 addr", 32'(wr_addr[base+2]), 32'd1);
            check("zero key wr3 addr", 32'(wr_addr[base+3]), 32'd1);
        end else begin
            check("zero key writes present", 32'(wr_addr.size()), 32'(base + 4));
        end
`ifdef KSA_INIT_EN
        errs = 0;
        for (int k = 0; k < 256 && k < wr_addr.size(); k++)
            if (wr_addr[k] != 8'(k) || wr_data[k] != 8'(k)) errs++;
        check("init fill order", 32'(errs), 32'd0);
`endif

        // "Key": known first RC4 keystream byte.
        preload_identity();
        launch(24'h4B6579);
        await_finish(0, 1'b0, 1'b0, "Key");
        check("Key keystream0", 32'(first_keystream()), 32'hEB);

        // Random keys; one with start re-pulsed mid-run.
        for (int r = 0; r < 3; r++) begin
            preload_identity();
            key = KW'($urandom());
            launch(key);
            await_finish(0, 1'b0, (r == 1), "random key");
        end

        // Reset at cycle 1000 of a run, then a clean rerun.
        preload_identity();
        launch(KW'($urandom()));
        for (int n = 1; n < 1000; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort write_en", 32'(write_en), 32'd0);
        check("abort address", 32'(address), 32'd0);
        check("abort data", 32'(data), 32'd0);
        check("abort finished", 32'(finished), 32'd0);
        sz = wr_addr.size();
        repeat (20) @(negedge clk);
        check("abort no writes", 32'(wr_addr.size()), 32'(sz));
        preload_identity();
        launch(KW'($urandom()));
        await_finish(0, 1'b0, 1'b0, "after abort");

        // start held across DONE: second run follows on the shuffled table.
        preload_identity();
        key = KW'($urandom());
        launch(key);
        await_finish(0, 1'b1, 1'b0, "held run1");
        prep_model(key);
        await_finish(-1, 1'b0, 1'b0, "held run2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
